// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and defaults for the intersection traffic blocks
package traffic_pkg;

  typedef enum logic { DENS_LOW = 1'b0, DENS_HIGH = 1'b1 } dens_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_WINDOW_CYCLES   = 64;
  localparam int DEF_CNT_W           = 8;
  localparam int DEF_HIGH_THRESH     = 6;
  localparam int DEF_LOW_THRESH      = 3;
  localparam int DEF_STUCK_WINDOWS   = 4;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } light_colour_t;

  typedef enum logic [2:0] {
    CTRL_NS_GREEN  = 3'd0,
    CTRL_NS_YELLOW = 3'd1,
    CTRL_ALL_RED_A = 3'd2,
    CTRL_EW_GREEN  = 3'd3,
    CTRL_EW_YELLOW = 3'd4,
    CTRL_ALL_RED_B = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// rtl/traffic_sensor_conditioner_if.sv - raw detector inputs and conditioned density outputs
interface traffic_sensor_conditioner_if #(
  parameter int CNT_W = traffic_pkg::DEF_CNT_W
);
  logic             det_ns_raw;
  logic             det_ew_raw;
  logic             sensor_ns;
  logic             sensor_ew;
  logic [CNT_W-1:0] count_ns;
  logic [CNT_W-1:0] count_ew;
  logic             window_done;
  logic             stuck_ns;
  logic             stuck_ew;

  modport master (
    output det_ns_raw, det_ew_raw,
    input  sensor_ns, sensor_ew, count_ns, count_ew, window_done, stuck_ns, stuck_ew
  );

  modport slave (
    input  det_ns_raw, det_ew_raw,
    output sensor_ns, sensor_ew, count_ns, count_ew, window_done, stuck_ns, stuck_ew
  );
endinterface

// File: rtl/traffic_sensor_channel.sv
// rtl/traffic_sensor_channel.sv - sync, debounce, windowed count and density flag for one approach
// Optional stuck-high fault detection: SENSOR_STUCK_DETECT_EN
module traffic_sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int HIGH_THRESH     = DEF_HIGH_THRESH,
  parameter int LOW_THRESH      = DEF_LOW_THRESH
`ifdef SENSOR_STUCK_DETECT_EN
  , parameter int STUCK_WINDOWS = DEF_STUCK_WINDOWS
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_raw,
  input  logic             terminal,
  output logic             sensor,
  output logic [CNT_W-1:0] count,
  output logic             stuck
);
  localparam int               DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(HIGH_THRESH);
  localparam logic [CNT_W-1:0] LOW_CNT  = CNT_W'(LOW_THRESH);

  logic             sync1, sync2, level, level_prev, rise;
  logic [DB_W-1:0]  db_cnt;
  logic [CNT_W-1:0] live, total;
  dens_state_t      flag;

  assign rise  = level & ~level_prev;
  assign total = (rise && live != CNT_MAX) ? live + CNT_W'(1) : live;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync1      <= det_raw;
      sync2      <= sync1;
      level_prev <= level;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // The flag decision uses total, the same value loaded into count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live  <= '0;
      count <= '0;
      flag  <= DENS_LOW;
    end else if (terminal) begin
      live  <= '0;
      count <= total;
      case (flag)
        DENS_LOW:  if (total >= HIGH_CNT) flag <= DENS_HIGH;
        DENS_HIGH: if (total <= LOW_CNT)  flag <= DENS_LOW;
        default:   flag <= DENS_LOW;
      endcase
    end else begin
      live <= total;
    end
  end

`ifdef SENSOR_STUCK_DETECT_EN
  localparam int             SW_W    = $clog2(STUCK_WINDOWS + 1);
  localparam logic [SW_W-1:0] STUCK_N = SW_W'(STUCK_WINDOWS);

  logic [SW_W-1:0] high_windows;
  logic            saw_low, fall;

  assign fall = ~level & level_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_windows <= '0;
      saw_low      <= 1'b0;
    end else begin
      if (terminal)    saw_low <= 1'b0;
      else if (!level) saw_low <= 1'b1;
      if (fall) begin
        high_windows <= '0;
      end else if (terminal) begin
        if (!saw_low && level) begin
          if (high_windows != STUCK_N) high_windows <= high_windows + SW_W'(1);
        end else begin
          high_windows <= '0;
        end
      end
    end
  end

  assign stuck  = (high_windows == STUCK_N);
  assign sensor = (flag == DENS_HIGH) && !stuck;
`else
  assign stuck  = 1'b0;
  assign sensor = (flag == DENS_HIGH);
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// rtl/traffic_sensor_conditioner.sv - shared window timer driving NS and EW sensor channels
// Optional stuck-high fault detection: SENSOR_STUCK_DETECT_EN
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int HIGH_THRESH     = DEF_HIGH_THRESH,
  parameter int LOW_THRESH      = DEF_LOW_THRESH
`ifdef SENSOR_STUCK_DETECT_EN
  , parameter int STUCK_WINDOWS = DEF_STUCK_WINDOWS
`endif
) (
  input logic                         clk,
  input logic                         reset,
  traffic_sensor_conditioner_if.slave bus
);
  localparam int              TW     = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0]   T_LAST = TW'(WINDOW_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          terminal, done_q;

  assign terminal        = (timer == T_LAST);
  assign bus.window_done = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer  <= '0;
      done_q <= 1'b0;
    end else begin
      timer  <= terminal ? '0 : timer + TW'(1);
      done_q <= terminal;
    end
  end

  traffic_sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W),
    .HIGH_THRESH(HIGH_THRESH), .LOW_THRESH(LOW_THRESH)
`ifdef SENSOR_STUCK_DETECT_EN
    , .STUCK_WINDOWS(STUCK_WINDOWS)
`endif
  ) u_ns (
    .clk(clk), .reset(reset), .det_raw(bus.det_ns_raw), .terminal(terminal),
    .sensor(bus.sensor_ns), .count(bus.count_ns), .stuck(bus.stuck_ns)
  );

  traffic_sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W),
    .HIGH_THRESH(HIGH_THRESH), .LOW_THRESH(LOW_THRESH)
`ifdef SENSOR_STUCK_DETECT_EN
    , .STUCK_WINDOWS(STUCK_WINDOWS)
`endif
  ) u_ew (
    .clk(clk), .reset(reset), .det_raw(bus.det_ew_raw), .terminal(terminal),
    .sensor(bus.sensor_ew), .count(bus.count_ew), .stuck(bus.stuck_ew)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb/tb_traffic_sensor_conditioner.sv - two configurations checked against a window-level model
// Stuck-detector expectations follow SENSOR_STUCK_DETECT_EN
module tb_traffic_sensor_conditioner;
  localparam int DEB = 4, HI = 6, LO = 3, STUCK_N = 4;
`ifdef SENSOR_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, det_ns = 1'b0, det_ew = 1'b0;
  int   checks = 0, errors = 0;
  bit   armed = 1'b0;

  traffic_sensor_conditioner_if #(.CNT_W(8)) bus_a ();
  traffic_sensor_conditioner_if #(.CNT_W(3)) bus_b ();
  assign bus_a.det_ns_raw = det_ns;
  assign bus_a.det_ew_raw = det_ew;
  assign bus_b.det_ns_raw = det_ns;
  assign bus_b.det_ew_raw = det_ew;

  traffic_sensor_conditioner #(.DEBOUNCE_CYCLES(DEB), .WINDOW_CYCLES(64), .CNT_W(8),
    .HIGH_THRESH(HI), .LOW_THRESH(LO)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  traffic_sensor_conditioner #(.DEBOUNCE_CYCLES(DEB), .WINDOW_CYCLES(256), .CNT_W(3),
    .HIGH_THRESH(HI), .LOW_THRESH(LO)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  // Reference: level follows the synchronised input once the last DEB samples all disagree with it.
  int unsigned win [2] = '{64, 256};
  int unsigned cmax[2] = '{255, 7};
  logic [15:0] rawhist[2];
  bit          lvl[2], prv[2];
  int unsigned m_timer[2], m_live[2][2], m_count[2][2], m_hw[2][2];
  bit          m_flag[2][2], m_allhigh[2][2], m_done[2];

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      rawhist[ch] = '0; lvl[ch] = 1'b0; prv[ch] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      m_timer[d] = 0; m_done[d] = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        m_live[d][ch] = 0; m_count[d][ch] = 0; m_hw[d][ch] = 0;
        m_flag[d][ch] = 1'b0; m_allhigh[d][ch] = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    bit rawnow[2], rise[2], fall[2];
    bit term, flip, cur_all;
    int unsigned tot;
    rawnow[0] = det_ns; rawnow[1] = det_ew;
    for (int ch = 0; ch < 2; ch++) begin
      rise[ch] = lvl[ch] && !prv[ch];
      fall[ch] = !lvl[ch] && prv[ch];
    end
    for (int d = 0; d < 2; d++) begin
      term = (m_timer[d] == win[d] - 1);
      for (int ch = 0; ch < 2; ch++) begin
        tot = m_live[d][ch] + (rise[ch] ? 1 : 0);
        if (tot > cmax[d]) tot = cmax[d];
        cur_all = m_allhigh[d][ch] && lvl[ch];
        if (term) begin
          m_count[d][ch] = tot;
          m_live[d][ch]  = 0;
          if (tot >= HI) m_flag[d][ch] = 1'b1;
          else if (tot <= LO) m_flag[d][ch] = 1'b0;
        end else begin
          m_live[d][ch] = tot;
        end
        if (fall[ch]) m_hw[d][ch] = 0;
        else if (term) m_hw[d][ch] = cur_all ? ((m_hw[d][ch] < STUCK_N) ? m_hw[d][ch] + 1 : STUCK_N) : 0;
        m_allhigh[d][ch] = term ? 1'b1 : cur_all;
      end
      m_done[d]  = term;
      m_timer[d] = term ? 0 : m_timer[d] + 1;
    end
    for (int ch = 0; ch < 2; ch++) begin
      flip = 1'b1;
      for (int i = 1; i <= DEB; i++) if (rawhist[ch][i] == lvl[ch]) flip = 1'b0;
      prv[ch] = lvl[ch];
      if (flip) lvl[ch] = !lvl[ch];
      rawhist[ch] = {rawhist[ch][14:0], rawnow[ch]};
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  function automatic int exp_stuck(int d, int ch);
    return (STUCK_EN && m_hw[d][ch] == STUCK_N) ? 1 : 0;
  endfunction

  function automatic int exp_sensor(int d, int ch);
    return (m_flag[d][ch] && exp_stuck(d, ch) == 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed && !reset) begin
      check("a_done",      int'(bus_a.window_done), int'(m_done[0]));
      check("a_count_ns",  int'(bus_a.count_ns),    int'(m_count[0][0]));
      check("a_count_ew",  int'(bus_a.count_ew),    int'(m_count[0][1]));
      check("a_sensor_ns", int'(bus_a.sensor_ns),   exp_sensor(0, 0));
      check("a_sensor_ew", int'(bus_a.sensor_ew),   exp_sensor(0, 1));
      check("a_stuck_ns",  int'(bus_a.stuck_ns),    exp_stuck(0, 0));
      check("a_stuck_ew",  int'(bus_a.stuck_ew),    exp_stuck(0, 1));
      check("b_done",      int'(bus_b.window_done), int'(m_done[1]));
      check("b_count_ns",  int'(bus_b.count_ns),    int'(m_count[1][0]));
      check("b_count_ew",  int'(bus_b.count_ew),    int'(m_count[1][1]));
      check("b_sensor_ns", int'(bus_b.sensor_ns),   exp_sensor(1, 0));
      check("b_sensor_ew", int'(bus_b.sensor_ew),   exp_sensor(1, 1));
      check("b_stuck_ns",  int'(bus_b.stuck_ns),    exp_stuck(1, 0));
      check("b_stuck_ew",  int'(bus_b.stuck_ew),    exp_stuck(1, 1));
    end
  end

  task automatic drive(input bit ns, input bit ew, input int n);
    det_ns = ns; det_ew = ew;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      drive(1'b1, 1'b0, 5);
      drive(1'b0, 1'b0, 5);
    end
  endtask

  task automatic wait_done(input bit on_b, output int cycles);
    bit seen;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 600) begin
      @(negedge clk);
      cycles++;
      seen = on_b ? bus_b.window_done : bus_a.window_done;
    end
    check("window_done_seen", int'(seen), 1);
  endtask

  initial begin
    int cyc;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_count_ns",  int'(bus_a.count_ns),    0);
    check("rst_sensor_ns", int'(bus_a.sensor_ns),   0);
    check("rst_done",      int'(bus_a.window_done), 0);
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;

    // Idle windows
    wait_done(1'b0, cyc);
    check("first_done_cycles", cyc, 64);
    for (int w = 0; w < 2; w++) begin
      check("idle_count_ns", int'(bus_a.count_ns), 0);
      check("idle_count_ew", int'(bus_a.count_ew), 0);
      check("idle_sensor_ns", int'(bus_a.sensor_ns), 0);
      wait_done(1'b0, cyc);
      check("done_interval", cyc, 64);
    end

    // Short glitch rejected, longer pulse counted
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 5);
    drive(1'b0, 1'b0, 10);
    wait_done(1'b0, cyc);
    check("debounce_count_ns", int'(bus_a.count_ns), 1);

    // Hysteresis over three windows
    pulses(6);
    wait_done(1'b0, cyc);
    check("w6_count_ns", int'(bus_a.count_ns), 6);
    check("w6_sensor_ns", int'(bus_a.sensor_ns), 1);
    pulses(4);
    wait_done(1'b0, cyc);
    check("w4_count_ns", int'(bus_a.count_ns), 4);
    check("w4_sensor_ns", int'(bus_a.sensor_ns), 1);
    pulses(3);
    wait_done(1'b0, cyc);
    check("w3_count_ns", int'(bus_a.count_ns), 3);
    check("w3_sensor_ns", int'(bus_a.sensor_ns), 0);

    // Debounced rises land in the terminal cycle on both channels
    drive(1'b0, 1'b0, 57);
    det_ns = 1'b1; det_ew = 1'b1;
    wait_done(1'b0, cyc);
    check("term_count_ns", int'(bus_a.count_ns), 1);
    check("term_count_ew", int'(bus_a.count_ew), 1);
    wait_done(1'b0, cyc);
    check("after_term_ns", int'(bus_a.count_ns), 0);
    check("after_term_ew", int'(bus_a.count_ew), 0);
    drive(1'b0, 1'b0, 10);

    // Saturation on the 3-bit counter instance
    wait_done(1'b1, cyc);
    pulses(10);
    wait_done(1'b1, cyc);
    check("sat_count_ns_b", int'(bus_b.count_ns), 7);

    // Reset mid-window with events pending
    wait_done(1'b0, cyc);
    pulses(6);
    wait_done(1'b0, cyc);
    pulses(2);
    drive(1'b0, 1'b0, 10);
    #2 reset = 1'b1;
    #1;
    check("midrst_count_ns", int'(bus_a.count_ns), 0);
    check("midrst_sensor_ns", int'(bus_a.sensor_ns), 0);
    check("midrst_done", int'(bus_a.window_done), 0);
    check("midrst_count_ns_b", int'(bus_b.count_ns), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_done(1'b0, cyc);
    check("post_rst_done_cycles", cyc, 64);

`ifdef SENSOR_STUCK_DETECT_EN
    det_ew = 1'b1;
    repeat (6) wait_done(1'b0, cyc);
    check("stuck_ew_set", int'(bus_a.stuck_ew), 1);
    check("stuck_sensor_ew", int'(bus_a.sensor_ew), 0);
    drive(1'b0, 1'b0, 8);
    check("stuck_ew_clear", int'(bus_a.stuck_ew), 0);
`endif

    // Random bouncy traffic on both approaches
    repeat (250) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    repeat (40) drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 80)));
    drive(1'b0, 1'b0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
